// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// The master side is the controller: it receives the instruction fields,
// ALU flags and memory handshake, and drives every datapath control.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       negative;
  logic       overflow;
  logic       mem_ready;

  logic       memread;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, negative, overflow, mem_ready,
    output memread, memwrite, iord, irwrite, pcen, pcsrc,
           regwrite, regdst, memtoreg, alusrca, alusrcb, alucontrol,
           illegal, state
  );

  modport slave (
    output op, funct, zero, negative, overflow, mem_ready,
    input  memread, memwrite, iord, irwrite, pcen, pcsrc,
           regwrite, regdst, memtoreg, alusrca, alusrcb, alucontrol,
           illegal, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: one FSM state per instruction phase, driving a
// shared-memory datapath. Memory phases stretch until mem_ready. Outputs are
// decoded combinationally from the current state, so there is no extra
// output latency. BLE, SLTI and illegal-instruction trapping are optional.
module mips_multicycle_ctrl #(
  parameter bit SUPPORT_BLE     = 1'b1,
  parameter bit SUPPORT_SLTI    = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  // R-type function codes this core implements.
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010, 6'b101011: funct_legal = 1'b1;
      default:                         funct_legal = 1'b0;
    endcase
  endfunction

  // ALU operation for an R-type funct; only legal functs reach EXEC.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b101011: funct_alu = ALU_SLTU;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  // Branch decision from the A-B subtraction flags. BLE uses the signed
  // less-than (negative ^ overflow) so it stays correct on overflow.
  function automatic logic branch_taken(input logic [5:0] o, input logic z,
                                        input logic n, input logic v);
    if (o == OP_BEQ)                     branch_taken = z;
    else if (o == OP_BNE)                branch_taken = ~z;
    else if (SUPPORT_BLE && o == OP_BLE) branch_taken = z | (n ^ v);
    else                                 branch_taken = 1'b0;
  endfunction

  state_t     state_q;
  state_t     state_d;
  state_t     illegal_target;
  logic       illegal_q;
  logic       is_slti;

  logic       memread_c;
  logic       memwrite_c;
  logic       iord_c;
  logic       irwrite_c;
  logic       pcen_c;
  logic [1:0] pcsrc_c;
  logic       regwrite_c;
  logic       regdst_c;
  logic       memtoreg_c;
  logic       alusrca_c;
  logic [1:0] alusrcb_c;
  logic [2:0] alucontrol_c;

  // An undecodable instruction either traps or falls back to FETCH; the PC
  // was already advanced in FETCH, so the fallback behaves as a NOP.
  assign illegal_target = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
  assign is_slti        = SUPPORT_SLTI && (bus.op == OP_SLTI);

  // State register; asynchronous reset returns straight to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Sticky illegal flag, raised on the transition into TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      illegal_q <= 1'b0;
    else if (state_d == S_TRAP && state_q != S_TRAP) illegal_q <= 1'b1;
  end

  // Next-state logic; mem_ready is only consulted in the memory phases.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.op == OP_LW || bus.op == OP_SW)
          state_d = S_MEMADR;
        else if (bus.op == OP_RTYPE)
          state_d = funct_legal(bus.funct) ? S_EXEC : illegal_target;
        else if (bus.op == OP_ADDI || is_slti)
          state_d = S_IMMEX;
        else if (bus.op == OP_BEQ || bus.op == OP_BNE ||
                 (SUPPORT_BLE && bus.op == OP_BLE))
          state_d = S_BRANCH;
        else if (bus.op == OP_J)
          state_d = S_JUMP;
        else
          state_d = illegal_target;
      end
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath controls per state; strobes are forced low while in reset so
  // no partial register or memory write can slip out.
  always_comb begin
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    iord_c       = 1'b0;
    irwrite_c    = 1'b0;
    pcen_c       = 1'b0;
    pcsrc_c      = 2'b00;
    regwrite_c   = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    alucontrol_c = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        memread_c    = 1'b1;
        alusrcb_c    = 2'b01;
        alucontrol_c = ALU_ADD;
        irwrite_c    = bus.mem_ready;
        pcen_c       = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb_c    = 2'b11;
        alucontrol_c = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_EXEC: begin
        alusrca_c    = 1'b1;
        alucontrol_c = funct_alu(bus.funct);
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      S_IMMEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = is_slti ? ALU_SLT : ALU_ADD;
      end
      S_IMMWB: regwrite_c = 1'b1;
      S_BRANCH: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        pcen_c       = branch_taken(bus.op, bus.zero, bus.negative, bus.overflow);
      end
      S_JUMP: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
      end
      S_TRAP:  ;
      default: ;
    endcase
    if (!reset) begin
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      pcen_c     = 1'b0;
      regwrite_c = 1'b0;
    end
  end

  assign bus.memread    = memread_c;
  assign bus.memwrite   = memwrite_c;
  assign bus.iord       = iord_c;
  assign bus.irwrite    = irwrite_c;
  assign bus.pcen       = pcen_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.regwrite   = regwrite_c;
  assign bus.regdst     = regdst_c;
  assign bus.memtoreg   = memtoreg_c;
  assign bus.alusrca    = alusrca_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.alucontrol = alucontrol_c;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Two instances share stimulus: dut_a uses
// the default parameters, dut_b has BLE/SLTI disabled and illegal-as-NOP.
// Each stimulus cycle queues the expected control vector; a negedge monitor
// pops and compares one entry per cycle.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if if_a ();
  mips_multicycle_ctrl_if if_b ();

  assign if_b.op        = if_a.op;
  assign if_b.funct     = if_a.funct;
  assign if_b.zero      = if_a.zero;
  assign if_b.negative  = if_a.negative;
  assign if_b.overflow  = if_a.overflow;
  assign if_b.mem_ready = if_a.mem_ready;

  mips_multicycle_ctrl dut_a (.clk(clk), .reset(reset), .bus(if_a));

  mips_multicycle_ctrl #(
    .SUPPORT_BLE(1'b0), .SUPPORT_SLTI(1'b0), .TRAP_ON_ILLEGAL(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  logic [20:0] vec_a;
  logic [20:0] vec_b;
  assign vec_a = {if_a.memread, if_a.memwrite, if_a.iord, if_a.irwrite, if_a.pcen,
                  if_a.pcsrc, if_a.regwrite, if_a.regdst, if_a.memtoreg, if_a.alusrca,
                  if_a.alusrcb, if_a.alucontrol, if_a.illegal, if_a.state};
  assign vec_b = {if_b.memread, if_b.memwrite, if_b.iord, if_b.irwrite, if_b.pcen,
                  if_b.pcsrc, if_b.regwrite, if_b.regdst, if_b.memtoreg, if_b.alusrca,
                  if_b.alusrcb, if_b.alucontrol, if_b.illegal, if_b.state};

  typedef struct {
    bit          w;
    logic [20:0] v;
    string       nm;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected controls for one cycle, straight from the per-state output table.
  function automatic logic [20:0] e(input logic [3:0] s, input logic mr,
                                    input logic tk, input logic [2:0] alu,
                                    input logic ill, input logic rs);
    logic rd, wr, io, ir, pe, rw, rdst, m2r, sa;
    logic [1:0] ps, sb;
    logic [2:0] ac;
    {rd, wr, io, ir, pe, rw, rdst, m2r, sa} = '0;
    ps = 2'b00; sb = 2'b00; ac = 3'b000;
    case (s)
      S_FETCH:  begin rd = 1; sb = 2'b01; ac = 3'b010; ir = mr; pe = mr; end
      S_DECODE: begin sb = 2'b11; ac = 3'b010; end
      S_MEMADR: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_MEMRD:  begin rd = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin wr = 1; io = 1; end
      S_EXEC:   begin sa = 1; ac = alu; end
      S_ALUWB:  begin rw = 1; rdst = 1; end
      S_IMMEX:  begin sa = 1; sb = 2'b10; ac = alu; end
      S_IMMWB:  rw = 1;
      S_BRANCH: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = tk; end
      S_JUMP:   begin ps = 2'b10; pe = 1; end
      default:  ;
    endcase
    if (rs) begin rd = 0; wr = 0; ir = 0; pe = 0; rw = 0; end
    return {rd, wr, io, ir, pe, ps, rw, rdst, m2r, sa, sb, ac, ill, s};
  endfunction

  // Monitor: one expected vector per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    chk_t        c;
    logic [20:0] act;
    if (q.size() > 0) begin
      c   = q.pop_front();
      act = c.w ? vec_b : vec_a;
      checks++;
      if (act !== c.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                 c.nm, act, c.v, act[3:0], c.v[3:0]);
      end
    end
  end

  task automatic step(input bit w, input logic [3:0] s, input logic mr,
                      input logic tk, input logic [2:0] alu, input logic ill,
                      input string nm);
    chk_t c;
    if_a.mem_ready = mr;
    c.w  = w;
    c.v  = e(s, mr, tk, alu, ill, ~reset);
    c.nm = nm;
    q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f);
    if_a.op    = o;
    if_a.funct = f;
  endtask

  task automatic flags(input logic z, input logic n, input logic v);
    if_a.zero     = z;
    if_a.negative = n;
    if_a.overflow = v;
  endtask

  logic [5:0] fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
  logic [2:0] al_tab [5] = '{3'b110,    3'b000,    3'b001,    3'b111,    3'b011};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr(6'b100011, 6'b000000);
    flags(0, 0, 0);
    if_a.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset: FETCH, strobes low even with mem_ready high
    step(0, S_FETCH, 1, 0, 0, 0, "reset_a");
    step(1, S_FETCH, 1, 0, 0, 0, "reset_b");
    reset = 1'b1;

    // R-type add
    instr(6'b000000, 6'b100000);
    step(0, S_FETCH,  1, 0, 0, 0, "add_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "add_decode");
    step(0, S_EXEC,   1, 0, 3'b010, 0, "add_exec");
    step(0, S_ALUWB,  1, 0, 0, 0, "add_aluwb");

    // Remaining R-type functs
    for (int i = 0; i < 5; i++) begin
      instr(6'b000000, fn_tab[i]);
      step(0, S_FETCH,  1, 0, 0, 0, "r_fetch");
      step(0, S_DECODE, 0, 0, 0, 0, "r_decode");
      step(0, S_EXEC,   0, 0, al_tab[i], 0, "r_exec");
      step(0, S_ALUWB,  1, 0, 0, 0, "r_aluwb");
    end

    // LW with 2 fetch waits and 3 read waits; early mem_ready ignored
    instr(6'b100011, 6'b000000);
    step(0, S_FETCH,  0, 0, 0, 0, "lw_fetch_w1");
    step(0, S_FETCH,  0, 0, 0, 0, "lw_fetch_w2");
    step(0, S_FETCH,  1, 0, 0, 0, "lw_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "lw_decode");
    step(0, S_MEMADR, 1, 0, 0, 0, "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, S_MEMRD, 0, 0, 0, 0, "lw_memrd_wait");
    step(0, S_MEMRD,  1, 0, 0, 0, "lw_memrd");
    step(0, S_MEMWB,  0, 0, 0, 0, "lw_memwb");

    // SW, no waits
    instr(6'b101011, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "sw_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "sw_decode");
    step(0, S_MEMADR, 1, 0, 0, 0, "sw_memadr");
    step(0, S_MEMWR,  1, 0, 0, 0, "sw_memwr");

    // ADDI and SLTI
    instr(6'b001000, 6'b111111);
    step(0, S_FETCH,  1, 0, 0, 0, "addi_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "addi_decode");
    step(0, S_IMMEX,  1, 0, 3'b010, 0, "addi_immex");
    step(0, S_IMMWB,  1, 0, 0, 0, "addi_immwb");
    instr(6'b001010, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "slti_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "slti_decode");
    step(0, S_IMMEX,  1, 0, 3'b111, 0, "slti_immex");
    step(0, S_IMMWB,  1, 0, 0, 0, "slti_immwb");

    // Branches
    instr(6'b000100, 6'b000000); flags(1, 0, 0);
    step(0, S_FETCH,  1, 0, 0, 0, "beq_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "beq_decode");
    step(0, S_BRANCH, 1, 1, 0, 0, "beq_taken");
    instr(6'b000101, 6'b000000); flags(0, 0, 0);
    step(0, S_FETCH,  1, 0, 0, 0, "bne_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "bne_decode");
    step(0, S_BRANCH, 1, 1, 0, 0, "bne_taken");
    instr(6'b000101, 6'b000000); flags(1, 0, 0);
    step(0, S_FETCH,  1, 0, 0, 0, "bne2_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "bne2_decode");
    step(0, S_BRANCH, 1, 0, 0, 0, "bne_not_taken");
    instr(6'b000110, 6'b000000); flags(0, 1, 0);
    step(0, S_FETCH,  1, 0, 0, 0, "ble_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "ble_decode");
    step(0, S_BRANCH, 1, 1, 0, 0, "ble_neg_taken");
    instr(6'b000110, 6'b000000); flags(0, 1, 1);
    step(0, S_FETCH,  1, 0, 0, 0, "ble2_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "ble2_decode");
    step(0, S_BRANCH, 1, 0, 0, 0, "ble_ovf_not_taken");
    flags(0, 0, 0);

    // Jump
    instr(6'b000010, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "j_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "j_decode");
    step(0, S_JUMP,   1, 0, 0, 0, "j_jump");

    // SW interrupted by reset while waiting in MEMWR
    instr(6'b101011, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "swr_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "swr_decode");
    step(0, S_MEMADR, 1, 0, 0, 0, "swr_memadr");
    step(0, S_MEMWR,  0, 0, 0, 0, "swr_memwr_wait");
    reset = 1'b0;
    step(0, S_FETCH,  0, 0, 0, 0, "swr_reset_drop");
    reset = 1'b1;
    step(0, S_FETCH,  0, 0, 0, 0, "swr_after_release");

    // Illegal opcode traps; sticky, strobes silent for 20 cycles
    instr(6'b111111, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "trap_fetch");
    step(0, S_DECODE, 1, 0, 0, 0, "trap_decode");
    for (int i = 0; i < 20; i++)
      step(0, S_TRAP, logic'(i[0]), 0, 0, 1, "trap_hold");
    reset = 1'b0;
    instr(6'b001010, 6'b000000);
    step(0, S_FETCH,  1, 0, 0, 0, "trap_reset_a");
    step(1, S_FETCH,  1, 0, 0, 0, "trap_reset_b");
    reset = 1'b1;

    // dut_b: SLTI, BLE and bad funct become NOPs; a legal OR still executes
    step(1, S_FETCH,  1, 0, 0, 0, "b_slti_fetch");
    step(1, S_DECODE, 1, 0, 0, 0, "b_slti_decode");
    instr(6'b000110, 6'b000000); flags(1, 0, 0);
    step(1, S_FETCH,  1, 0, 0, 0, "b_slti_nop");
    step(1, S_DECODE, 1, 0, 0, 0, "b_ble_decode");
    instr(6'b000000, 6'b111111);
    step(1, S_FETCH,  1, 0, 0, 0, "b_ble_nop");
    step(1, S_DECODE, 1, 0, 0, 0, "b_badfn_decode");
    instr(6'b000000, 6'b100101);
    step(1, S_FETCH,  1, 0, 0, 0, "b_badfn_nop");
    step(1, S_DECODE, 1, 0, 0, 0, "b_or_decode");
    step(1, S_EXEC,   1, 0, 3'b001, 0, "b_or_exec");
    step(1, S_ALUWB,  1, 0, 0, 0, "b_or_aluwb");
    step(1, S_FETCH,  0, 0, 0, 0, "b_final_fetch");

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle controller FSM for the next-generation MIPS core. It replaces the single-cycle decoder with one FSM, one state per instruction phase, driving a shared-memory multicycle datapath. Memory accesses stretch with a ready handshake. BLE/SLTI support and illegal-opcode trapping are selectable by parameter.

Parameters:
SUPPORT_BLE, 1, 1 = opcode 000110 (BLE) is legal; 0 = treated as illegal
SUPPORT_SLTI, 1, 1 = opcode 001010 (SLTI) is legal; 0 = treated as illegal
TRAP_ON_ILLEGAL, 1, 1 = illegal op/funct enters TRAP; 0 = executes as NOP (returns to FETCH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0]
zero, negative, overflow  in  1 each  ALU flags (negative = aluresult[31])
mem_ready  in  1  memory completes current access this cycle
memread, memwrite  out  1  memory strobes
iord  out  1  0 = address from PC, 1 = ALUOut
irwrite  out  1  load instruction register
pcen  out  1  PC write enable
pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
regwrite, regdst, memtoreg  out  1  register-file controls
alusrca  out  1  0 = PC, 1 = A register
alusrcb  out  2  00 B, 01 constant 4, 10 signimm, 11 signimm<<2
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sltu
illegal  out  1  sticky; set on TRAP entry
state  out  4  current state encoding, for debug

Behaviour:
- Async reset (reset=0): state=FETCH, illegal=0. All strobes (memread, memwrite, irwrite, pcen, regwrite) forced 0 while reset=0. Mux selects are don't-care but are driven to the FETCH values.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, TRAP.
- Unlisted outputs are 0.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, add (branch target into ALUOut).
  - Next state by op: 100011/101011→MEMADR; 000000 with legal funct→EXEC; 001000→IMMEX; SLTI (if enabled)→IMMEX; 000100/000101/BLE (if enabled)→BRANCH; 000010→JUMP; else illegal.
- Legal funct values: 100000, 100010, 100100, 100101, 101010, 101011.
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: memread=1, iord=1. Wait on mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWR: memwrite=1, iord=1. Hold memwrite until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol decoded from funct. Then ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- IMMEX: alusrca=1, alusrcb=10; add for ADDI, 111 for SLTI. Then IMMWB.
- IMMWB: regwrite=1, regdst=0. Then FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen=taken, where BEQ: zero; BNE: ~zero; BLE: zero | (negative ^ overflow).
  - Then FETCH.
- JUMP: pcsrc=10, pcen=1. Then FETCH.
- Illegal handling:
  - TRAP_ON_ILLEGAL=1: go to TRAP. Set illegal=1. All strobes stay 0, and TRAP is only left via reset.
  - TRAP_ON_ILLEGAL=0: return to FETCH. PC has already advanced, so the instruction acts as a NOP.
- Cycle counts with mem_ready always 1: R/ADDI/SLTI 4; LW 5; SW 4; branch 3; J 3. Each wait cycle adds 1.
- mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored elsewhere. A mem_ready that arrives early (in another state) has no effect.
- Reset asserted mid-instruction: immediate return to FETCH; no partial register or memory write completes after reset assertion.
- Outputs are combinational from state (plus mem_ready, flags and op in the cases above). No output registers, so there is no extra latency.

Test Plan:
- op=000000 funct=100000, mem_ready=1 → states FETCH,DECODE,EXEC,ALUWB; alucontrol=010 in EXEC; regwrite=1, regdst=1 only in ALUWB; back to FETCH at cycle 5.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total; irwrite/pcen pulse exactly once, in the mem_ready cycle; memread held throughout MEMRD.
- BLE with zero=0, negative=1, overflow=0 → pcen=1, pcsrc=01 in BRANCH. Repeat with negative=1, overflow=1 → pcen=0. BNE with zero=0 → pcen=1.
- op=111111, TRAP_ON_ILLEGAL=1 → TRAP after DECODE, illegal=1, no strobes for 20 cycles. Then reset=0 → FETCH, illegal=0.
- SUPPORT_SLTI=0, op=001010 → treated as illegal. Same with TRAP_ON_ILLEGAL=0 → FETCH after DECODE, regwrite never asserted.
- SW with reset pulled low during MEMWR (mem_ready=0) → memwrite drops the same cycle, state=FETCH after release, no write pulse.
